// File: rtl/mrf_nw_ckpt.sv
// mrf_nw_ckpt: multi-write / multi-read register file with a circular
// queue of full-contents checkpoints that can be taken, released (oldest
// first) and restored (any live slot, freeing it and every younger one).
// Optional same-cycle write-to-read forwarding is enabled by defining the
// macro NCPU_RF_BYPASS_EN.
module mrf_nw_ckpt #(
  parameter int              DW         = 32,
  parameter int              AW         = 5,
  parameter logic [DW-1:0]   RST_VECTOR = '0,
  parameter int              NUM_WRITE  = 2,
  parameter int              NUM_READ   = 2,
  parameter int              CW         = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_WRITE-1:0]    WE,
  input  logic [AW*NUM_WRITE-1:0] WADDR,
  input  logic [DW*NUM_WRITE-1:0] WDATA,
  input  logic [AW*NUM_READ-1:0]  RADDR,
  output logic [DW*NUM_READ-1:0]  RDATA,
  input  logic                    CKPT_TAKE,
  output logic                    CKPT_RDY,
  output logic [CW-1:0]           CKPT_ID,
  input  logic                    CKPT_RESTORE,
  input  logic [CW-1:0]           CKPT_RID,
  input  logic                    CKPT_RELEASE,
  output logic [CW:0]             CKPT_CNT
);

  localparam int NENT = 1 << AW;
  localparam int NCK  = 1 << CW;
  localparam logic [CW:0] full_cnt = NCK[CW:0];

  logic [DW-1:0] mem      [NENT];
  logic [DW-1:0] wr_next  [NENT];
  logic [DW-1:0] slots    [NCK][NENT];
  logic [CW-1:0] head;
  logic [CW-1:0] tail;
  logic [CW:0]   cnt;

  logic [CW-1:0] rdist;
  logic          rst_valid;
  logic          rel_ok;
  logic          take_ok;

  // Queue status and acceptance of restore / release / take this cycle.
  // The release is resolved before the take so a full queue can still
  // accept a take when it frees its oldest slot in the same cycle.
  always_comb begin
    rdist     = CKPT_RID - head;
    rst_valid = CKPT_RESTORE && ({1'b0, rdist} < cnt);
    rel_ok    = CKPT_RELEASE && (cnt != '0) && !rst_valid;
    take_ok   = CKPT_TAKE && !rst_valid && ((cnt != full_cnt) || rel_ok);
    CKPT_RDY  = (cnt != full_cnt);
    CKPT_ID   = tail;
    CKPT_CNT  = cnt;
  end

  // Contents after this cycle's writes; later ports override earlier ones.
  always_comb begin
    for (int i = 0; i < NENT; i++) begin
      wr_next[i] = mem[i];
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (WE[j] && (WADDR[j*AW +: AW] == AW'(i))) begin
          wr_next[i] = WDATA[j*DW +: DW];
        end
      end
    end
  end

  // Read ports: registered contents, or forwarded write data when enabled
  // and no restore is about to replace the whole file.
  always_comb begin
    RDATA = '0;
    for (int k = 0; k < NUM_READ; k++) begin
`ifdef NCPU_RF_BYPASS_EN
      if (rst_valid) begin
        RDATA[k*DW +: DW] = mem[RADDR[k*AW +: AW]];
      end else begin
        RDATA[k*DW +: DW] = wr_next[RADDR[k*AW +: AW]];
      end
`else
      RDATA[k*DW +: DW] = mem[RADDR[k*AW +: AW]];
`endif
    end
  end

  // Register contents: reset value, restored snapshot, or merged writes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NENT; i++) begin
        mem[i] <= RST_VECTOR;
      end
    end else if (rst_valid) begin
      for (int i = 0; i < NENT; i++) begin
        mem[i] <= slots[CKPT_RID][i];
      end
    end else begin
      for (int i = 0; i < NENT; i++) begin
        mem[i] <= wr_next[i];
      end
    end
  end

  // Queue pointers: a restore rewinds tail to the restored slot, otherwise
  // take advances tail and release advances head.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (rst_valid) begin
      tail <= CKPT_RID;
      cnt  <= {1'b0, rdist};
    end else begin
      if (take_ok) begin
        tail <= tail + 1'b1;
      end
      if (rel_ok) begin
        head <= head + 1'b1;
      end
      case ({take_ok, rel_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Snapshot storage, never reset; a slot captured while reset is held is
  // unreachable because the count is cleared, so it is simply overwritten
  // by the next accepted take.
  always_ff @(posedge CLK) begin
    if (take_ok) begin
      for (int i = 0; i < NENT; i++) begin
        slots[tail][i] <= wr_next[i];
      end
    end
  end

endmodule

// File: tb/tb_mrf_nw_ckpt.sv
// tb_mrf_nw_ckpt: directed bench for mrf_nw_ckpt (DW=8, AW=2, two write and
// two read ports, four checkpoint slots). Expected values are hand-derived.
module tb_mrf_nw_ckpt;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int CW = 2;
  localparam logic [DW-1:0] RV = 8'hC3;

  logic          CLK;
  logic          RST;
  logic [1:0]    WE;
  logic [2*AW-1:0] WADDR;
  logic [2*DW-1:0] WDATA;
  logic [2*AW-1:0] RADDR;
  logic [2*DW-1:0] RDATA;
  logic          CKPT_TAKE;
  logic          CKPT_RDY;
  logic [CW-1:0] CKPT_ID;
  logic          CKPT_RESTORE;
  logic [CW-1:0] CKPT_RID;
  logic          CKPT_RELEASE;
  logic [CW:0]   CKPT_CNT;

  int compared = 0;
  int mismatched = 0;

  mrf_nw_ckpt #(
    .DW(DW), .AW(AW), .RST_VECTOR(RV), .NUM_WRITE(2), .NUM_READ(2), .CW(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RADDR(RADDR), .RDATA(RDATA), .CKPT_TAKE(CKPT_TAKE), .CKPT_RDY(CKPT_RDY),
    .CKPT_ID(CKPT_ID), .CKPT_RESTORE(CKPT_RESTORE), .CKPT_RID(CKPT_RID),
    .CKPT_RELEASE(CKPT_RELEASE), .CKPT_CNT(CKPT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's request; settles combinational outputs before return.
  task automatic applyStimulus(input logic [1:0] we, input logic [1:0] wa0, input logic [7:0] wd0,
                               input logic [1:0] wa1, input logic [7:0] wd1, input logic take,
                               input logic rest, input logic [1:0] rid, input logic rel);
    WE = we;
    WADDR = {wa1, wa0};
    WDATA = {wd1, wd0};
    CKPT_TAKE = take;
    CKPT_RESTORE = rest;
    CKPT_RID = rid;
    CKPT_RELEASE = rel;
    #1;
  endtask

  // Let the pending request hit a rising edge, then return to idle.
  task automatic tick();
    @(posedge CLK);
    #1;
    applyStimulus(2'b00, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // Read an entry through port 0 (or port 1) with idle controls.
  task automatic readEntry(input int port, input logic [1:0] addr, output logic [7:0] data);
    if (port == 0) RADDR[1:0] = addr; else RADDR[3:2] = addr;
    #1;
    data = (port == 0) ? RDATA[7:0] : RDATA[15:8];
  endtask

  initial begin
    logic [7:0] rd;
    RST = 1'b0;
    RADDR = '0;
    applyStimulus(2'b00, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    $display("[TB] reset state");
    readEntry(0, 2'd0, rd); checkOutput("rst_e0_p0", rd, RV);
    readEntry(1, 2'd3, rd); checkOutput("rst_e3_p1", rd, RV);
    checkOutput("rst_rdy", CKPT_RDY, 1);
    checkOutput("rst_id", CKPT_ID, 0);
    checkOutput("rst_cnt", CKPT_CNT, 0);
    RST = 1'b1;
    #1;

    $display("[TB] write-after-write priority");
    applyStimulus(2'b11, 2'd1, 8'h11, 2'd1, 8'h22, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    readEntry(1, 2'd1, rd); checkOutput("waw_e1", rd, 8'h22);

    $display("[TB] take and restore");
    applyStimulus(2'b01, 2'd2, 8'h5A, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
    checkOutput("take_id_before", CKPT_ID, 0);
    tick();
    checkOutput("take_cnt", CKPT_CNT, 1);
    checkOutput("take_id_after", CKPT_ID, 1);
    applyStimulus(2'b01, 2'd2, 8'hA5, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    readEntry(0, 2'd2, rd); checkOutput("pre_restore_e2", rd, 8'hA5);
    applyStimulus(2'b00, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    readEntry(0, 2'd2, rd); checkOutput("restore_e2", rd, 8'h5A);
    checkOutput("restore_cnt", CKPT_CNT, 0);
    checkOutput("restore_id", CKPT_ID, 0);

    $display("[TB] full queue");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b01, 2'd3, 8'h10 + 8'(k), 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
      tick();
    end
    checkOutput("full_rdy", CKPT_RDY, 0);
    checkOutput("full_cnt", CKPT_CNT, 4);
    checkOutput("full_id", CKPT_ID, 0);
    applyStimulus(2'b00, 2'd0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    checkOutput("full_take_ignored_cnt", CKPT_CNT, 4);
    checkOutput("full_take_ignored_id", CKPT_ID, 0);
    applyStimulus(2'b01, 2'd3, 8'h14, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("take_rel_cnt", CKPT_CNT, 4);
    checkOutput("take_rel_id", CKPT_ID, 1);
    // head is now 1, so slot 0 is the youngest: distance 3, leaving 3 live
    applyStimulus(2'b01, 2'd3, 8'h77, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    checkOutput("head1_restore_cnt", CKPT_CNT, 3);
    checkOutput("head1_restore_id", CKPT_ID, 0);
    readEntry(0, 2'd3, rd); checkOutput("head1_restore_e3", rd, 8'h14);

    $display("[TB] partial restore");
    RST = 1'b0;
    #1;
    checkOutput("rst2_cnt", CKPT_CNT, 0);
    readEntry(0, 2'd3, rd); checkOutput("rst2_e3", rd, RV);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 2'd0, 8'h00, 2'd0, 8'hA0 + 8'(k), 1'b1, 1'b0, 2'd0, 1'b0);
      tick();
    end
    checkOutput("three_cnt", CKPT_CNT, 3);
    checkOutput("three_id", CKPT_ID, 3);
    applyStimulus(2'b01, 2'd0, 8'hB1, 2'd0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b0);
    tick();
    checkOutput("bad_restore_cnt", CKPT_CNT, 3);
    checkOutput("bad_restore_id", CKPT_ID, 3);
    readEntry(0, 2'd0, rd); checkOutput("bad_restore_write", rd, 8'hB1);
    applyStimulus(2'b00, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    checkOutput("part_restore_cnt", CKPT_CNT, 1);
    checkOutput("part_restore_id", CKPT_ID, 1);
    readEntry(0, 2'd0, rd); checkOutput("part_restore_e0", rd, 8'hA1);

    $display("[TB] restore priority");
    RADDR[1:0] = 2'd0;
    applyStimulus(2'b01, 2'd0, 8'hFF, 2'd0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0);
    checkOutput("prio_no_forward", RDATA[7:0], 8'hA1);
    tick();
    readEntry(0, 2'd0, rd); checkOutput("prio_e0", rd, 8'hA0);
    readEntry(1, 2'd1, rd); checkOutput("prio_e1", rd, RV);
    checkOutput("prio_cnt", CKPT_CNT, 0);
    checkOutput("prio_id", CKPT_ID, 0);

    $display("[TB] bypass");
    RADDR[1:0] = 2'd3;
    applyStimulus(2'b01, 2'd3, 8'h3C, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
`ifdef NCPU_RF_BYPASS_EN
    checkOutput("bypass_same_cycle", RDATA[7:0], 8'h3C);
`else
    checkOutput("bypass_same_cycle", RDATA[7:0], RV);
`endif
    tick();
    readEntry(0, 2'd3, rd); checkOutput("bypass_next_cycle", rd, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mrf_nw_ckpt.md
MRF_NW_CKPT -- requirements
Module: mrf_nw_ckpt

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width per entry.
REQ-002 SHALL have parameter AW, default 5, meaning address width; the block holds 1<<AW entries.
REQ-003 SHALL have parameter RST_VECTOR, DW bits, default 0, meaning reset value of every entry.
REQ-004 SHALL have parameter NUM_WRITE, default 2, meaning number of write ports.
REQ-005 SHALL have parameter NUM_READ, default 2, meaning number of read ports.
REQ-006 SHALL have parameter CW, default 2, meaning checkpoint-id width; the block holds NCK = 1<<CW checkpoint slots.
REQ-007 SHALL have the following ports (name  direction  width  meaning):
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- WE  in  NUM_WRITE  per-port write enable.
- WADDR  in  AW*NUM_WRITE  write addresses, port j at slice j.
- WDATA  in  DW*NUM_WRITE  write data.
- RADDR  in  AW*NUM_READ  read addresses.
- RDATA  out  DW*NUM_READ  read data.
- CKPT_TAKE  in  1  snapshot request.
- CKPT_RDY  out  1  a free slot exists.
- CKPT_ID  out  CW  slot id the next accepted take will use.
- CKPT_RESTORE  in  1  restore request.
- CKPT_RID  in  CW  slot to restore.
- CKPT_RELEASE  in  1  free the oldest live checkpoint.
- CKPT_CNT  out  CW+1  number of live checkpoints.

Function
REQ-008 SHALL resolve same-cycle writes to one address by priority: the highest-indexed enabled port wins.
REQ-009 SHALL drive RDATA combinationally from registered contents (zero-latency read).
REQ-010 SHALL manage slots as a circular queue: head = oldest live slot, tail = next free slot, CKPT_ID = tail, CKPT_RDY = (CKPT_CNT != NCK).
REQ-011 SHALL accept a take only when CKPT_TAKE && CKPT_RDY; the slot stores the register contents including that cycle's writes; tail and count advance by 1, modulo NCK for tail.
REQ-012 SHALL ignore a take when the queue is full; no state changes except that cycle's writes.
REQ-013 SHALL act on a release only when CKPT_CNT != 0; head advances by 1 and count decrements by 1.
REQ-014 SHALL treat a restore as valid only when ((CKPT_RID - head) mod NCK) < CKPT_CNT.
REQ-015 SHALL, on a valid restore, load every entry from slot CKPT_RID on the next edge, set tail = CKPT_RID, and set count = (CKPT_RID - head) mod NCK; the restored slot and all younger slots are freed.
REQ-016 SHALL give a valid restore priority over writes, take and release issued in the same cycle; those are discarded.
REQ-017 SHALL ignore an invalid restore entirely; writes, take and release in that cycle proceed normally.
REQ-018 SHALL apply a take and a release in the same cycle together: count is unchanged, head and tail both advance; this is legal even when the queue is full, because the release is evaluated first.
REQ-019 SHALL leave checkpoint slot contents undefined until they are written; a slot is never read before a take fills it.

Reset
REQ-020 SHALL, while RST is low, asynchronously set every entry to RST_VECTOR, and set head = 0, tail = 0 and count = 0; consequently CKPT_RDY = 1, CKPT_ID = 0 and CKPT_CNT = 0.
REQ-021 SHALL discard any take, restore or release in progress when reset is asserted mid-cycle.
REQ-022 SHALL NOT reset checkpoint slot storage.

Configuration
REQ-023 SHALL, with NCPU_RF_BYPASS_EN defined, forward same-cycle write data to RDATA, using the REQ-008 priority among matching ports.
REQ-024 SHALL, without NCPU_RF_BYPASS_EN, present RDATA with the pre-edge contents only.
REQ-025 SHALL suppress forwarding in a cycle with a valid restore.

Verification (DW=8, AW=2, NUM_WRITE=2, NUM_READ=2, CW=2)
REQ-026 Bench SHALL check reset and WAW: after reset every RDATA = RST_VECTOR. Then WE=11, both ports addressing 1 with port0=0x11 and port1=0x22 -> entry1 = 0x22.
REQ-027 Bench SHALL check take/restore: write entry2 = 0x5A together with a take -> CKPT_ID was 0 and CKPT_CNT = 1. Write entry2 = 0xA5, then restore RID=0 -> entry2 = 0x5A and CKPT_CNT = 0.
REQ-028 Bench SHALL check full: 4 takes -> CKPT_RDY = 0 and CKPT_CNT = 4. A 5th take alone is ignored. Take plus release in one cycle -> CKPT_CNT stays 4, head = 1, CKPT_ID = 1.
REQ-029 Bench SHALL check partial restore: with 3 live slots (head 0), restore RID=1 -> CKPT_CNT = 1 and CKPT_ID = 1. A restore with RID=3 is ignored.
REQ-030 Bench SHALL check restore priority: restore concurrent with WE=01 writing entry0 = 0xFF and with CKPT_TAKE -> the write and the take are discarded and contents equal the slot.
REQ-031 Bench SHALL check bypass: with NCPU_RF_BYPASS_EN, RADDR = 3 while writing 0x3C to entry 3 -> RDATA = 0x3C in the same cycle. Without the macro, RDATA shows the old value that cycle and 0x3C the next.
